// File: rtl/radar_target_emulator.sv
// radar_target_emulator
// Target-side end of the ARTAU radar link. A rising edge on radar_pulse_trigger
// launches a round-trip flight for the modelled range; radar_echo is returned
// once the flight time has elapsed. After every echo the range closes by
// closing_speed, saturating at zero.
// Optional build macro: ECHO_JITTER_EN adds 0..3 LFSR-driven extra flight cycles.
//
// state  | meaning
// IDLE   | waiting for a trigger rise; range may be loaded
// FLIGHT | accumulating light travel until it covers the round trip
// ECHO   | driving radar_echo for ECHO_WIDTH cycles, then closing the range
module radar_target_emulator #(
  parameter int unsigned CYCLE_METERS = 300,
  parameter int unsigned MAX_RANGE    = 150000,
  parameter int unsigned ECHO_WIDTH   = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        radar_pulse_trigger,
  input  logic        target_present,
  input  logic [31:0] initial_range,
  input  logic        load_range,
  input  logic [31:0] closing_speed,
  output logic        radar_echo,
  output logic [31:0] current_range,
  output logic        busy,
  output logic        pulse_ignored,
  output logic [1:0]  emu_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_FLIGHT  = 2'b01,
    S_ECHO    = 2'b10,
    S_ILLEGAL = 2'b11
  } state_t;

  localparam int unsigned WCW = (ECHO_WIDTH > 1) ? $clog2(ECHO_WIDTH) : 1;
  localparam logic [WCW-1:0] WC_LOAD = WCW'(ECHO_WIDTH - 1);
  localparam logic [33:0] STEP = 34'(CYCLE_METERS);

  state_t          state_q, state_d;
  logic            trig_dly_q, trig_dly_d;
  logic [31:0]     range_q, range_d;
  logic [32:0]     rt_q, rt_d;
  logic [33:0]     acc_q, acc_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic            echo_q, echo_d;
  logic            ign_q, ign_d;
  logic            rise;

`ifdef ECHO_JITTER_EN
  logic [7:0]      lfsr_q, lfsr_d, lfsr_nxt;
  logic [1:0]      jit_q, jit_d;
`endif

  assign rise = radar_pulse_trigger & ~trig_dly_q;

`ifdef ECHO_JITTER_EN
  // Fibonacci LFSR, taps 8,6,5,4.
  assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

  // Next-state and datapath updates for the echo FSM.
  always_comb begin
    state_d    = state_q;
    trig_dly_d = radar_pulse_trigger;
    range_d    = range_q;
    rt_d       = rt_q;
    acc_d      = acc_q;
    wcnt_d     = wcnt_q;
    ign_d      = rise && (state_q != S_IDLE);
`ifdef ECHO_JITTER_EN
    lfsr_d     = lfsr_q;
    jit_d      = jit_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A load in the same cycle as a rise swallows that rise.
        if (load_range) begin
          range_d = initial_range;
        end else if (rise && target_present && (range_q <= MAX_RANGE)) begin
          rt_d    = {range_q, 1'b0};
          acc_d   = '0;
          state_d = S_FLIGHT;
`ifdef ECHO_JITTER_EN
          lfsr_d  = lfsr_nxt;
          jit_d   = lfsr_nxt[1:0];
`endif
        end
      end
      S_FLIGHT: begin
`ifdef ECHO_JITTER_EN
        if (jit_q != 2'd0) begin
          jit_d = jit_q - 2'd1;
        end else
`endif
        if (acc_q >= {1'b0, rt_q}) begin
          state_d = S_ECHO;
          wcnt_d  = WC_LOAD;
        end else begin
          acc_d = acc_q + STEP;
        end
      end
      S_ECHO: begin
        if (wcnt_q == '0) begin
          state_d = S_IDLE;
          range_d = (range_q > closing_speed) ? (range_q - closing_speed) : '0;
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    echo_d = (state_d == S_ECHO);
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      trig_dly_q <= 1'b0;
      range_q    <= '0;
      rt_q       <= '0;
      acc_q      <= '0;
      wcnt_q     <= '0;
      echo_q     <= 1'b0;
      ign_q      <= 1'b0;
`ifdef ECHO_JITTER_EN
      lfsr_q     <= 8'hA5;
      jit_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      trig_dly_q <= trig_dly_d;
      range_q    <= range_d;
      rt_q       <= rt_d;
      acc_q      <= acc_d;
      wcnt_q     <= wcnt_d;
      echo_q     <= echo_d;
      ign_q      <= ign_d;
`ifdef ECHO_JITTER_EN
      lfsr_q     <= lfsr_d;
      jit_q      <= jit_d;
`endif
    end
  end

  assign radar_echo    = echo_q;
  assign current_range = range_q;
  assign busy          = (state_q != S_IDLE);
  assign pulse_ignored = ign_q;
  assign emu_state     = state_q;

endmodule
